// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: round-robin shares one 5-bit Fibonacci LFSR among NREQ requesters, delivering WORD_W-bit random words over valid/ready
//   clk, rst_n (sync, active-low) | req[NREQ] level requests | gnt[NREQ] one-hot registered grant
//   rnd_data/rnd_valid/rnd_ready word handshake | seed_load/seed_in reseed while idle | busy = not idle
module lfsr_rng_arbiter #(
  parameter int         NREQ   = 4,
  parameter int         WORD_W = 8,
  parameter logic [4:0] SEED   = 5'b10010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  input  logic              seed_load,
  input  logic [4:0]        seed_in,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WORD_W);
  // SEED is written S0 first (MSB = S0); s_q[i] holds S[i]
  localparam logic [4:0] SEED_S = {SEED[0], SEED[1], SEED[2], SEED[3], SEED[4]};
  typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_t;
  state_t              state_q, state_d;
  logic [4:0]          s_q, s_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                lo_ok, hi_ok;
  logic [PW-1:0]       lo_idx, hi_idx;
  logic                fin;
  // lowest set request overall, and lowest set request at/after the pointer; the latter wins
  always_comb begin
    lo_ok  = 1'b0;
    lo_idx = '0;
    hi_ok  = 1'b0;
    hi_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_ok  = 1'b1;
        lo_idx = PW'(i);
        if (PW'(i) >= ptr_q) begin
          hi_ok  = 1'b1;
          hi_idx = PW'(i);
        end
      end
    end
  end
  // abort (granted request dropped) and handshake end a transaction identically
  assign fin = (state_q == SHIFT && !req[idx_q]) ||
               (state_q == DELIVER && (!req[idx_q] || rnd_ready));
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (fin) begin
      state_d = IDLE;
      gnt_d   = '0;
      valid_d = 1'b0;
      ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_load) begin
            s_d = (seed_in == 5'd0) ? SEED_S : seed_in;
          end else if (lo_ok) begin
            idx_d   = hi_ok ? hi_idx : lo_idx;
            gnt_d   = NREQ'(1) << (hi_ok ? hi_idx : lo_idx);
            cnt_d   = '0;
            data_d  = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          data_d = {data_q[WORD_W-2:0], s_q[4]};
          s_d    = {s_q[3:0], s_q[1] ^ s_q[4]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WORD_W - 1)) begin
            state_d = DELIVER;
            valid_d = 1'b1;
          end
        end
        DELIVER: ;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= SEED_S;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end
  assign gnt       = gnt_q;
  assign rnd_data  = data_q;
  assign rnd_valid = valid_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter: checks lfsr_rng_arbiter against a transaction-level model every cycle plus directed literal expectations
module tb_lfsr_rng_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [W-1:0] rnd_data;
  logic         rnd_valid;
  logic         rnd_ready = 1'b0;
  logic         seed_load = 1'b0;
  logic [4:0]   seed_in = '0;
  logic         busy;
  always #5 clk = ~clk;
  lfsr_rng_arbiter #(.NREQ(N), .WORD_W(W), .SEED(5'b10010)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .seed_load(seed_load),
    .seed_in(seed_in), .busy(busy)
  );
  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  bit       lf[5];
  bit       nx[5];
  bit       ob;
  bit       m_on = 1'b0;
  bit       m_have, m_valid;
  int       m_idx, m_ptr, m_bits;
  logic [W-1:0] m_word;
  always @(posedge clk) begin
    if (!rst_n) begin
      lf = '{1, 0, 0, 1, 0};
      m_on = 1'b1;
      m_have = 1'b0;
      m_valid = 1'b0;
      m_ptr = 0;
      m_idx = 0;
      m_bits = 0;
      m_word = '0;
    end else if (m_on) begin
      if (!m_have) begin
        if (seed_load) begin
          if (seed_in == 5'd0) lf = '{1, 0, 0, 1, 0};
          else for (int i = 0; i < 5; i++) lf[i] = seed_in[i];
        end else if (req != '0) begin
          for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
          m_have = 1'b1;
          m_bits = 0;
          m_word = '0;
        end
      end else if (!req[m_idx] || (m_valid && rnd_ready)) begin
        m_have = 1'b0;
        m_valid = 1'b0;
        m_ptr = (m_idx + 1) % N;
      end else if (!m_valid) begin
        ob = lf[4];
        nx[0] = lf[1] ^ lf[4];
        for (int i = 1; i < 5; i++) nx[i] = lf[i-1];
        lf = nx;
        m_word = (m_word << 1) | W'(ob);
        m_bits++;
        if (m_bits == W) m_valid = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (m_on) begin
      chk("gnt", 32'(gnt), m_have ? (32'd1 << m_idx) : 32'd0);
      chk("valid", 32'(rnd_valid), 32'(m_valid));
      chk("data", 32'(rnd_data), 32'(m_word));
      chk("busy", 32'(busy), 32'(m_have));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("valid_gnt", 32'(!rnd_valid || $onehot(gnt)), 32'd1);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!rnd_valid && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic wait_gnt(input bit nz, output int n);
    n = 0;
    while (((gnt != '0) != nz) && n < 40) begin
      tick();
      n++;
    end
  endtask
  int           n;
  logic [N-1:0] got[5];
  logic [N-1:0] exp3[5];
  logic [W-1:0] d;
  logic [N-1:0] g;
  initial begin
    exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_data", 32'(rnd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    req = 4'b0001;
    rnd_ready = 1'b1;
    tick();
    chk("t1_gnt", 32'(gnt), 1);
    wait_valid(n);
    chk("t1_latency", n, 8);
    chk("t1_word", 32'(rnd_data), 32'h48);
    chk("t1_model_word", 32'(m_word), 32'h48);
    chk("t1_model_lfsr", {27'd0, lf[0], lf[1], lf[2], lf[3], lf[4]}, 32'b01010);
    tick();
    chk("t2_gap", 32'(gnt), 0);
    tick();
    chk("t2_regrant", 32'(gnt), 1);
    wait_valid(n);
    chk("t2_latency", n, 8);
    chk("t2_word", 32'(rnd_data), 32'h57);
    req = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(1'b1, n);
      got[i] = gnt;
      wait_gnt(1'b0, n);
    end
    req = '0;
    for (int i = 0; i < 5; i++) chk("t3_rr_order", 32'(got[i]), 32'(exp3[i]));
    req = 4'b0001;
    rnd_ready = 1'b0;
    wait_valid(n);
    d = rnd_data;
    g = gnt;
    repeat (5) begin
      tick();
      chk("t4_hold_data", 32'(rnd_data), 32'(d));
      chk("t4_hold_gnt", 32'(gnt), 32'(g));
      chk("t4_hold_valid", 32'(rnd_valid), 1);
    end
    rnd_ready = 1'b1;
    tick();
    chk("t4_accept_valid", 32'(rnd_valid), 0);
    chk("t4_accept_gnt", 32'(gnt), 0);
    req = '0;
    seed_load = 1'b1;
    seed_in = 5'd0;
    tick();
    seed_load = 1'b0;
    req = 4'b0001;
    tick();
    chk("t5_gnt", 32'(gnt), 1);
    seed_load = 1'b1;
    seed_in = 5'h1f;
    tick();
    tick();
    seed_load = 1'b0;
    wait_valid(n);
    chk("t5_word", 32'(rnd_data), 32'h48);
    req = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b0100;
    tick();
    chk("t6_gnt2", 32'(gnt), 4);
    repeat (3) tick();
    req = 4'b1000;
    tick();
    chk("t6_abort_gnt", 32'(gnt), 0);
    chk("t6_abort_valid", 32'(rnd_valid), 0);
    chk("t6_abort_busy", 32'(busy), 0);
    tick();
    chk("t6_gnt3", 32'(gnt), 8);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_gnt", 32'(gnt), 0);
    chk("t6_rst_data", 32'(rnd_data), 0);
    chk("t6_rst_valid", 32'(rnd_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    req = '0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      rnd_ready = $urandom_range(0, 3) != 0;
      seed_load = $urandom_range(0, 15) == 0;
      seed_in = 5'($urandom);
      rst_n = $urandom_range(0, 299) != 0;
      tick();
    end
    rst_n = 1'b1;
    req = '0;
    seed_load = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
